// File: rtl/compressor_env.sv
// ---------------------------------------------------------------------------
// compressor_env: 3-stage dynamic-range processor with envelope follower
// (bypass / compress / limit / gate) and saturating makeup gain.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module compressor_env #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        mode,
  input  logic [CTRL_W-1:0] thres,
  input  logic [2:0]        ratio_shift,
  input  logic [3:0]        attack_shift,
  input  logic [3:0]        release_shift,
  input  logic [1:0]        makeup_shift,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic [DATA_W-2:0] env_out,
  output logic              active
);

  localparam int MW = DATA_W - 1;
  localparam logic [MW-1:0] MAG_MAX     = {MW{1'b1}};
  localparam logic [MW-1:0] MAG_ONE     = MW'(1);
  localparam logic [1:0]    MODE_BYPASS = 2'b00;
  localparam logic [1:0]    MODE_COMP   = 2'b01;
  localparam logic [1:0]    MODE_LIMIT  = 2'b10;
  localparam logic [1:0]    MODE_GATE   = 2'b11;

  // Stage 1 capture
  logic              s1_valid, s1_sign;
  logic [MW-1:0]     s1_mag, s1_t;
  logic [DATA_W-1:0] s1_data;
  logic [1:0]        s1_mode, s1_mk;
  logic [2:0]        s1_ratio;
  logic [3:0]        s1_att, s1_rel;

  logic [DATA_W-1:0] abs_in;
  logic [MW-1:0]     mag_in, t_in;

  assign abs_in = data_in[DATA_W-1] ? -data_in : data_in;
  // Only the most-negative input leaves the top bit set after negation.
  assign mag_in = abs_in[DATA_W-1] ? MAG_MAX : abs_in[MW-1:0];
  assign t_in   = MW'(thres) << (MW - CTRL_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_t     <= '0;
      s1_data  <= '0;
      s1_mode  <= MODE_BYPASS;
      s1_mk    <= '0;
      s1_ratio <= '0;
      s1_att   <= '0;
      s1_rel   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= data_in[DATA_W-1];
        s1_mag   <= mag_in;
        s1_t     <= t_in;
        s1_data  <= data_in;
        s1_mode  <= mode;
        s1_mk    <= makeup_shift;
        s1_ratio <= ratio_shift;
        s1_att   <= attack_shift;
        s1_rel   <= release_shift;
      end
    end
  end

  // Stage 2: envelope follower
  logic [MW-1:0] env, env_next, up_d, dn_d;
  logic          eng_next;

  assign up_d = (s1_mag - env) >> s1_att;
  assign dn_d = (env - s1_mag) >> s1_rel;

  always_comb begin
    env_next = env;
    // A step that truncates to zero is forced to one so the envelope converges.
    if (s1_mag > env)
      env_next = env + ((up_d == '0) ? MAG_ONE : up_d);
    else if (s1_mag < env)
      env_next = env - ((dn_d == '0) ? MAG_ONE : dn_d);
  end

  assign eng_next = (env_next > s1_t);

  logic              s2_valid, s2_sign, s2_eng;
  logic [MW-1:0]     s2_mag, s2_t;
  logic [DATA_W-1:0] s2_data;
  logic [1:0]        s2_mode, s2_mk;
  logic [2:0]        s2_ratio;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env      <= '0;
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_eng   <= 1'b0;
      s2_mag   <= '0;
      s2_t     <= '0;
      s2_data  <= '0;
      s2_mode  <= MODE_BYPASS;
      s2_mk    <= '0;
      s2_ratio <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        env      <= env_next;
        s2_sign  <= s1_sign;
        s2_eng   <= eng_next;
        s2_mag   <= s1_mag;
        s2_t     <= s1_t;
        s2_data  <= s1_data;
        s2_mode  <= s1_mode;
        s2_mk    <= s1_mk;
        s2_ratio <= s1_ratio;
      end
    end
  end

  assign env_out = env;

  // Stage 3: transfer curve, makeup, sign restore
  logic [MW-1:0]     m, m_mk;
  logic [MW+2:0]     mk_wide;
  logic              act_next;
  logic [DATA_W-1:0] out_next;

  always_comb begin
    m        = s2_mag;
    act_next = 1'b0;
    case (s2_mode)
      MODE_COMP: begin
        act_next = s2_eng;
        if (s2_eng && (s2_mag > s2_t))
          m = s2_t + ((s2_mag - s2_t) >> s2_ratio);
      end
      MODE_LIMIT: begin
        act_next = s2_eng;
        if (s2_eng && (s2_mag > s2_t))
          m = s2_t;
      end
      MODE_GATE: begin
        act_next = !s2_eng;
        if (!s2_eng)
          m = '0;
      end
      default: begin
        m        = s2_mag;
        act_next = 1'b0;
      end
    endcase
  end

  assign mk_wide  = {3'b000, m} << s2_mk;
  assign m_mk     = (|mk_wide[MW+2:MW]) ? MAG_MAX : mk_wide[MW-1:0];
  assign out_next = (s2_mode == MODE_BYPASS) ? s2_data :
                    (s2_sign ? -{1'b0, m_mk} : {1'b0, m_mk});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      active    <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        data_out <= out_next;
        active   <= act_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_compressor_env.sv
// ---------------------------------------------------------------------------
// tb_compressor_env: directed self-checking bench for compressor_env.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_compressor_env;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] data_in;
  logic [1:0]  mode;
  logic [7:0]  thres;
  logic [2:0]  ratio_shift;
  logic [3:0]  attack_shift;
  logic [3:0]  release_shift;
  logic [1:0]  makeup_shift;
  logic [15:0] data_out;
  logic        out_valid;
  logic [14:0] env_out;
  logic        active;

  int checks   = 0;
  int failures = 0;

  compressor_env #(.DATA_W(16), .CTRL_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .mode(mode), .thres(thres), .ratio_shift(ratio_shift),
    .attack_shift(attack_shift), .release_shift(release_shift),
    .makeup_shift(makeup_shift), .data_out(data_out), .out_valid(out_valid),
    .env_out(env_out), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] m, input logic [7:0] t, input logic [2:0] r,
                     input logic [3:0] a, input logic [3:0] rl, input logic [1:0] mk);
    mode = m; thres = t; ratio_shift = r;
    attack_shift = a; release_shift = rl; makeup_shift = mk;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated sample; returns the result and the strobe latency in clks.
  task automatic send(input int sample, output int dout, output int act,
                      output int env, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = sample[15:0];
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 10);
    check("out_valid_seen", int'(out_valid), 1);
    dout = int'($signed(data_out));
    act  = int'(active);
    env  = int'(env_out);
  endtask

  int d, a, e, l, prev, seen;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; data_in = '0;
    cfg(2'b00, 8'h40, 3'd2, 4'd0, 4'd4, 2'd0);
    repeat (2) @(negedge clk);
    check("rst_data_out", int'($signed(data_out)), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_env", int'(env_out), 0);
    check("rst_active", int'(active), 0);
    rst = 1'b0;

    // Bypass, most-negative sample, exact latency and one-clk strobe
    send(-32768, d, a, e, l);
    check("byp_latency", l, 3);
    check("byp_data", d, -32768);
    check("byp_active", a, 0);
    @(negedge clk);
    check("byp_strobe_width", int'(out_valid), 0);

    // Compress
    do_reset();
    cfg(2'b01, 8'h40, 3'd2, 4'd0, 4'd4, 2'd0);
    send(16384, d, a, e, l);
    check("comp_env", e, 16384);
    check("comp_data", d, 10240);
    check("comp_active", a, 1);
    send(-16384, d, a, e, l);
    check("comp_neg_data", d, -10240);
    check("comp_neg_active", a, 1);

    // Limit
    cfg(2'b10, 8'h40, 3'd2, 4'd0, 4'd4, 2'd0);
    send(30000, d, a, e, l);
    check("lim_env", e, 30000);
    check("lim_data", d, 8192);
    send(4000, d, a, e, l);
    check("lim_env2", e, 28375);
    check("lim_below_data", d, 4000);
    check("lim_below_active", a, 1);

    // Release with back-to-back samples (bypass so outputs are easy to predict)
    do_reset();
    cfg(2'b00, 8'h40, 3'd2, 4'd0, 4'd4, 2'd0);
    @(negedge clk); in_valid = 1'b1; data_in = 16'd16384;
    @(negedge clk); data_in = 16'd0;
    @(negedge clk); data_in = 16'd0;
    check("b2b_env0", int'(env_out), 16384);
    check("b2b_ov_early", int'(out_valid), 0);
    @(negedge clk); in_valid = 1'b0;
    check("b2b_env1", int'(env_out), 15360);
    check("b2b_ov0", int'(out_valid), 1);
    check("b2b_data0", int'($signed(data_out)), 16384);
    @(negedge clk);
    check("b2b_env2", int'(env_out), 14400);
    check("b2b_ov1", int'(out_valid), 1);
    check("b2b_data1", int'($signed(data_out)), 0);
    @(negedge clk);
    check("b2b_ov2", int'(out_valid), 1);
    @(negedge clk);
    check("b2b_ov_end", int'(out_valid), 0);
    check("idle_no_decay", int'(env_out), 14400);

    prev = 14400;
    for (int i = 0; i < 40; i++) begin
      send(0, d, a, e, l);
      check("rel_monotonic", int'(e < prev && e > 0), 1);
      prev = e;
    end

    // Minimum release step of one
    do_reset();
    send(5, d, a, e, l);
    check("min_env_start", e, 5);
    for (int i = 0; i < 5; i++) begin
      send(0, d, a, e, l);
      check("min_step_env", e, 4 - i);
    end
    send(0, d, a, e, l);
    check("min_env_floor", e, 0);

    // Gate
    do_reset();
    cfg(2'b11, 8'h40, 3'd2, 4'd0, 4'd4, 2'd0);
    send(100, d, a, e, l);
    check("gate_closed_data", d, 0);
    check("gate_closed_active", a, 1);
    send(20000, d, a, e, l);
    check("gate_open_data", d, 20000);
    check("gate_open_active", a, 0);

    // Makeup and saturation
    cfg(2'b01, 8'hFF, 3'd2, 4'd0, 4'd4, 2'd3);
    send(20000, d, a, e, l);
    check("sat_pos", d, 32767);
    send(-32768, d, a, e, l);
    check("sat_neg", d, -32767);
    send(1000, d, a, e, l);
    check("mk_pos", d, 8000);
    send(-1000, d, a, e, l);
    check("mk_neg", d, -8000);

    // Reset mid-pipeline
    do_reset();
    cfg(2'b01, 8'h40, 3'd2, 4'd0, 4'd4, 2'd0);
    send(1000, d, a, e, l);
    check("pre_rst_env", e, 1000);
    @(negedge clk); in_valid = 1'b1; data_in = 16'd16384;
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    #1;
    check("midrst_env", int'(env_out), 0);
    check("midrst_data", int'($signed(data_out)), 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("midrst_no_strobe", seen, 0);
    send(16384, d, a, e, l);
    check("post_rst_env", e, 16384);
    check("post_rst_data", d, 10240);
    check("post_rst_active", a, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
